// File: rtl/mseq_pkg.sv
// mseq_pkg: shared definitions for the micro-sequencer.
//   - opcode_t  : instruction opcodes RSTALL..RSTI
//   - state_t   : sequencer FSM states
//   - START_TBL : first micro-address of each opcode's routine
//   - LEN_TBL   : routine length in micro-steps (1..3)
//   - TRAP_ADDR : micro-address of the illegal-instruction trap step
package mseq_pkg;

   localparam int NUM_OPS   = 16;
   localparam int TRAP_ADDR = 24;

   typedef enum logic [3:0] {
      OP_RSTALL, OP_CONST, OP_MOV,   OP_SIZE,
      OP_SUB,    OP_JMPNZ, OP_MOV02, OP_ADDX,
      OP_ADDY,   OP_MUL,   OP_ADD,   OP_LOAD,
      OP_MOV13,  OP_INCI,  OP_STORE, OP_RSTI
   } opcode_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_TRAP
   } state_t;

   localparam logic [4:0] START_TBL [NUM_OPS] = '{
      5'd1,  5'd2,  5'd4,  5'd5,  5'd7,  5'd8,  5'd10, 5'd11,
      5'd12, 5'd13, 5'd16, 5'd17, 5'd19, 5'd20, 5'd21, 5'd23
   };

   localparam logic [1:0] LEN_TBL [NUM_OPS] = '{
      2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd1,
      2'd1, 2'd3, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2, 2'd1
   };

endpackage

// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: instruction handshake and micro-address bus.
//   Handshake: an instruction transfers on a rising clk edge where
//   ir_valid and ir_ready are both high. ir must be stable while
//   ir_valid is high; ir_ready may depend combinationally on stall/zflag.
//   slave  modport : the sequencer (consumes ir/controls, drives uaddr etc.)
//   master modport : the instruction source / datapath side
//   dbg_state      : sequencer FSM state, for observation only
interface micro_sequencer_if
   import mseq_pkg::*;
#(
   parameter int IR_W    = 8,
   parameter int UADDR_W = 5
) ();

   logic [IR_W-1:0]    ir;
   logic               ir_valid;
   logic               ir_ready;
   logic               zflag;
   logic               stall;
   logic               err_clr;
   logic [UADDR_W-1:0] uaddr;
   logic               uvalid;
   logic               ulast;
   logic               illegal_err;
   state_t             dbg_state;

   modport slave (
      input  ir, ir_valid, zflag, stall, err_clr,
      output ir_ready, uaddr, uvalid, ulast, illegal_err, dbg_state
   );

   modport master (
      output ir, ir_valid, zflag, stall, err_clr,
      input  ir_ready, uaddr, uvalid, ulast, illegal_err, dbg_state
   );

endinterface

// File: rtl/mseq_map.sv
// mseq_map: combinational opcode -> {start address, length, legal} ROM.
//   ir    : instruction word; opcode is ir[IR_W-1 -: OPC_W]
//   start : first micro-address of the routine
//   len   : routine length (1..3)
//   legal : low operand bits are zero and opcode is within the table
module mseq_map
   import mseq_pkg::*;
#(
   parameter int IR_W    = 8,
   parameter int OPC_W   = 4,
   parameter int UADDR_W = 5
) (
   input  logic [IR_W-1:0]    ir,
   output logic [UADDR_W-1:0] start,
   output logic [1:0]         len,
   output logic               legal
);

   logic [OPC_W-1:0] op;
   logic [3:0]       idx;
   logic             low_zero;
   logic             op_in_range;

   assign op  = ir[IR_W-1 -: OPC_W];
   assign idx = 4'(op);

   generate
      if (IR_W > OPC_W) begin : g_low
         assign low_zero = (ir[IR_W-OPC_W-1:0] == '0);
      end else begin : g_no_low
         assign low_zero = 1'b1;
      end
      // Only a wider opcode field can name an entry past the table.
      if (OPC_W > 4) begin : g_wide_op
         assign op_in_range = (op[OPC_W-1:4] == '0);
      end else begin : g_narrow_op
         assign op_in_range = 1'b1;
      end
   endgenerate

   assign start = UADDR_W'(START_TBL[idx]);
   assign len   = LEN_TBL[idx];
   assign legal = low_zero & op_in_range;

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: accepts instruction words and steps the micro-address
// through each opcode's microroutine.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : ir/ir_valid/ir_ready handshake, zflag, stall, err_clr,
//                 uaddr/uvalid/ulast, sticky illegal_err, dbg_state
//   retired_cnt : completed legal routines, 16-bit wrapping
//                 (present only with MICRO_SEQUENCER_PERF_EN defined)
module micro_sequencer
   import mseq_pkg::*;
#(
   parameter int IR_W    = 8,
   parameter int OPC_W   = 4,
   parameter int UADDR_W = 5
) (
   input  logic clk,
   input  logic rst_n,
   micro_sequencer_if.slave bus
`ifdef MICRO_SEQUENCER_PERF_EN
   ,
   output logic [15:0] retired_cnt
`endif
);

   state_t             state_q, state_d;
   logic [UADDR_W-1:0] uaddr_q, uaddr_d;
   logic               uvalid_q, uvalid_d;
   logic               ulast_q, ulast_d;
   logic [1:0]         step_q, step_d;
   logic [1:0]         len_q, len_d;
   logic               jmpnz_q, jmpnz_d;
   logic               err_q, err_d;

   logic [UADDR_W-1:0] map_start;
   logic [1:0]         map_len;
   logic               map_legal;
   logic               jmp_exit;
   logic               ulast_eff;
   logic               ready;
   logic               accept;

   mseq_map #(.IR_W(IR_W), .OPC_W(OPC_W), .UADDR_W(UADDR_W)) u_map (
      .ir    (bus.ir),
      .start (map_start),
      .len   (map_len),
      .legal (map_legal)
   );

   // JMPNZ ends at step 0 when zflag is set; a stalled cycle does not sample it.
   assign jmp_exit  = (state_q == S_EXEC) & jmpnz_q & (step_q == 2'd0) &
                      bus.zflag & ~bus.stall;
   assign ulast_eff = ulast_q | jmp_exit;
   assign ready     = (state_q == S_IDLE) |
                      ((state_q == S_EXEC) & ulast_eff & ~bus.stall);
   assign accept    = bus.ir_valid & ready;

   always_comb begin
      state_d  = state_q;
      uaddr_d  = uaddr_q;
      uvalid_d = uvalid_q;
      ulast_d  = ulast_q;
      step_d   = step_q;
      len_d    = len_q;
      jmpnz_d  = jmpnz_q;
      err_d    = bus.err_clr ? 1'b0 : err_q;

      case (state_q)
         S_EXEC: begin
            if (!bus.stall) begin
               if (ulast_eff) begin
                  state_d  = S_IDLE;
                  uaddr_d  = '0;
                  uvalid_d = 1'b0;
                  ulast_d  = 1'b0;
               end else begin
                  step_d  = step_q + 2'd1;
                  uaddr_d = uaddr_q + UADDR_W'(1);
                  ulast_d = ((step_q + 2'd1) == (len_q - 2'd1));
               end
            end
         end
         S_TRAP: begin
            state_d  = S_IDLE;
            uaddr_d  = '0;
            uvalid_d = 1'b0;
            ulast_d  = 1'b0;
         end
         default: ;
      endcase

      // A new instruction overrides the idle/finish transition above.
      if (accept) begin
         uvalid_d = 1'b1;
         step_d   = 2'd0;
         if (map_legal) begin
            state_d = S_EXEC;
            uaddr_d = map_start;
            len_d   = map_len;
            ulast_d = (map_len == 2'd1);
            jmpnz_d = (bus.ir[IR_W-1 -: OPC_W] == OPC_W'(OP_JMPNZ));
         end else begin
            state_d = S_TRAP;
            uaddr_d = UADDR_W'(TRAP_ADDR);
            len_d   = 2'd1;
            ulast_d = 1'b1;
            jmpnz_d = 1'b0;
            err_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         uaddr_q  <= '0;
         uvalid_q <= 1'b0;
         ulast_q  <= 1'b0;
         step_q   <= 2'd0;
         len_q    <= 2'd1;
         jmpnz_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         uaddr_q  <= uaddr_d;
         uvalid_q <= uvalid_d;
         ulast_q  <= ulast_d;
         step_q   <= step_d;
         len_q    <= len_d;
         jmpnz_q  <= jmpnz_d;
         err_q    <= err_d;
      end
   end

   assign bus.ir_ready    = ready;
   assign bus.uaddr       = uaddr_q;
   assign bus.uvalid      = uvalid_q;
   assign bus.ulast       = ulast_eff;
   assign bus.illegal_err = err_q;
   assign bus.dbg_state   = state_q;

`ifdef MICRO_SEQUENCER_PERF_EN
   logic [15:0] retired_q, retired_d;

   always_comb begin
      retired_d = retired_q;
      if ((state_q == S_EXEC) & uvalid_q & ulast_eff & ~bus.stall) begin
         retired_d = retired_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_q <= 16'd0;
      end else begin
         retired_q <= retired_d;
      end
   end

   assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed and randomized checks of micro_sequencer.
module tb_micro_sequencer;
  import mseq_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  micro_sequencer_if #(.IR_W(8), .UADDR_W(5)) bus ();

`ifdef MICRO_SEQUENCER_PERF_EN
  logic [15:0] retired_cnt;
`endif

  micro_sequencer #(.IR_W(8), .OPC_W(4), .UADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MICRO_SEQUENCER_PERF_EN
    ,
    .retired_cnt (retired_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference tables, straight from the opcode table
  int start_ref [16] = '{1, 2, 4, 5, 7, 8, 10, 11, 12, 13, 16, 17, 19, 20, 21, 23};
  int len_ref   [16] = '{1, 2, 1, 2, 1, 2, 1, 1, 1, 3, 1, 2, 1, 1, 2, 1};

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.ir       = 8'h00;
    bus.ir_valid = 1'b0;
    bus.zflag    = 1'b0;
    bus.stall    = 1'b0;
    bus.err_clr  = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] word);
    bus.ir       = word;
    bus.ir_valid = 1'b1;
    next_cycle();
    bus.ir_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (bus.uaddr !== 5'd0)     begin n_bad++; $display("FAIL reset_uaddr got %0d want 0", bus.uaddr); end
    n_vec++; if (bus.uvalid !== 1'b0)    begin n_bad++; $display("FAIL reset_uvalid got %0b want 0", bus.uvalid); end
    n_vec++; if (bus.ulast !== 1'b0)     begin n_bad++; $display("FAIL reset_ulast got %0b want 0", bus.ulast); end
    n_vec++; if (bus.illegal_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %0b want 0", bus.illegal_err); end
    n_vec++; if (bus.ir_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_ready got %0b want 1", bus.ir_ready); end
`ifdef MICRO_SEQUENCER_PERF_EN
    n_vec++; if (retired_cnt !== 16'd0)  begin n_bad++; $display("FAIL reset_retired got %0d want 0", retired_cnt); end
`endif
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_mul();
    bus.ir = 8'h90;
    bus.ir_valid = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.ir_ready !== 1'b1) begin n_bad++; $display("FAIL mul_accept_ready got %0b want 1", bus.ir_ready); end
    next_cycle();
    bus.ir_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++; if (bus.uaddr !== 5'(13 + k)) begin n_bad++; $display("FAIL mul_uaddr k=%0d got %0d want %0d", k, bus.uaddr, 13 + k); end
      n_vec++; if (bus.uvalid !== 1'b1)      begin n_bad++; $display("FAIL mul_uvalid k=%0d got %0b want 1", k, bus.uvalid); end
      n_vec++; if (bus.ulast !== (k == 2))   begin n_bad++; $display("FAIL mul_ulast k=%0d got %0b want %0b", k, bus.ulast, k == 2); end
      n_vec++; if (bus.ir_ready !== (k == 2)) begin n_bad++; $display("FAIL mul_ready k=%0d got %0b want %0b", k, bus.ir_ready, k == 2); end
      next_cycle();
    end
    @(negedge clk);
    n_vec++; if (bus.uvalid !== 1'b0 || bus.uaddr !== 5'd0) begin n_bad++; $display("FAIL mul_idle got uvalid=%0b uaddr=%0d want 0/0", bus.uvalid, bus.uaddr); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    int exp_a [4] = '{13, 14, 15, 16};
    bit exp_l [4] = '{0, 0, 1, 1};
    offer(8'h90);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin bus.ir = 8'hA0; bus.ir_valid = 1'b1; end
      else bus.ir_valid = 1'b0;
      @(negedge clk);
      n_vec++; if (bus.uaddr !== 5'(exp_a[k])) begin n_bad++; $display("FAIL b2b_uaddr k=%0d got %0d want %0d", k, bus.uaddr, exp_a[k]); end
      n_vec++; if (bus.uvalid !== 1'b1)        begin n_bad++; $display("FAIL b2b_uvalid k=%0d got %0b want 1", k, bus.uvalid); end
      n_vec++; if (bus.ulast !== exp_l[k])     begin n_bad++; $display("FAIL b2b_ulast k=%0d got %0b want %0b", k, bus.ulast, exp_l[k]); end
      next_cycle();
    end
    bus.ir_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.uvalid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got uvalid=%0b want 0", bus.uvalid); end
    next_cycle();
  endtask

  task automatic test_jmpnz();
    // taken: zflag=1 ends after uaddr 8
    bus.zflag = 1'b1;
    offer(8'h50);
    @(negedge clk);
    n_vec++; if (bus.uaddr !== 5'd8 || bus.ulast !== 1'b1) begin n_bad++; $display("FAIL jmpnz_z1 got uaddr=%0d ulast=%0b want 8/1", bus.uaddr, bus.ulast); end
    next_cycle();
    @(negedge clk);
    n_vec++; if (bus.uvalid !== 1'b0) begin n_bad++; $display("FAIL jmpnz_z1_end got uvalid=%0b want 0", bus.uvalid); end
    next_cycle();
    // not taken: zflag=0 runs 8, 9
    bus.zflag = 1'b0;
    offer(8'h50);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_vec++; if (bus.uaddr !== 5'(8 + k) || bus.ulast !== (k == 1) || bus.uvalid !== 1'b1) begin
        n_bad++; $display("FAIL jmpnz_z0 k=%0d got uaddr=%0d ulast=%0b want %0d/%0b", k, bus.uaddr, bus.ulast, 8 + k, k == 1);
      end
      next_cycle();
    end
    @(negedge clk);
    n_vec++; if (bus.uvalid !== 1'b0) begin n_bad++; $display("FAIL jmpnz_z0_end got uvalid=%0b want 0", bus.uvalid); end
    next_cycle();
  endtask

  task automatic test_stall();
    int exp_a [5] = '{17, 17, 17, 17, 18};
    offer(8'hB0);
    for (int k = 0; k < 5; k++) begin
      bus.stall = (k < 3);
      @(negedge clk);
      n_vec++; if (bus.uaddr !== 5'(exp_a[k])) begin n_bad++; $display("FAIL stall_uaddr k=%0d got %0d want %0d", k, bus.uaddr, exp_a[k]); end
      n_vec++; if (bus.uvalid !== 1'b1)        begin n_bad++; $display("FAIL stall_uvalid k=%0d got %0b want 1", k, bus.uvalid); end
      n_vec++; if (bus.ir_ready !== (k == 4))  begin n_bad++; $display("FAIL stall_ready k=%0d got %0b want %0b", k, bus.ir_ready, k == 4); end
      n_vec++; if (bus.ulast !== (k == 4))     begin n_bad++; $display("FAIL stall_ulast k=%0d got %0b want %0b", k, bus.ulast, k == 4); end
      next_cycle();
    end
    bus.stall = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.uvalid !== 1'b0) begin n_bad++; $display("FAIL stall_end got uvalid=%0b want 0", bus.uvalid); end
    next_cycle();
  endtask

  task automatic test_illegal();
    logic [7:0] words [2] = '{8'h02, 8'hF1};
    for (int w = 0; w < 2; w++) begin
      offer(words[w]);
      @(negedge clk);
      n_vec++; if (bus.uaddr !== 5'd24 || bus.uvalid !== 1'b1 || bus.ulast !== 1'b1) begin
        n_bad++; $display("FAIL trap_step w=%0d got uaddr=%0d uvalid=%0b ulast=%0b want 24/1/1", w, bus.uaddr, bus.uvalid, bus.ulast);
      end
      n_vec++; if (bus.ir_ready !== 1'b0)    begin n_bad++; $display("FAIL trap_ready w=%0d got %0b want 0", w, bus.ir_ready); end
      n_vec++; if (bus.illegal_err !== 1'b1) begin n_bad++; $display("FAIL trap_err w=%0d got %0b want 1", w, bus.illegal_err); end
      next_cycle();
      @(negedge clk);
      n_vec++; if (bus.uvalid !== 1'b0 || bus.illegal_err !== 1'b1 || bus.ir_ready !== 1'b1) begin
        n_bad++; $display("FAIL trap_after w=%0d got uvalid=%0b err=%0b ready=%0b want 0/1/1", w, bus.uvalid, bus.illegal_err, bus.ir_ready);
      end
      next_cycle();
    end
    bus.err_clr = 1'b1;
    next_cycle();
    bus.err_clr = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.illegal_err !== 1'b0) begin n_bad++; $display("FAIL err_clear got %0b want 0", bus.illegal_err); end
    next_cycle();
    // set wins over clear in the same cycle
    bus.err_clr = 1'b1;
    offer(8'h02);
    bus.err_clr = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.illegal_err !== 1'b1) begin n_bad++; $display("FAIL err_set_priority got %0b want 1", bus.illegal_err); end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_async_reset();
    offer(8'h90);
    @(negedge clk);
    n_vec++; if (bus.uaddr !== 5'd13) begin n_bad++; $display("FAIL areset_pre got %0d want 13", bus.uaddr); end
    next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.uaddr !== 5'd0 || bus.uvalid !== 1'b0 || bus.ulast !== 1'b0) begin
      n_bad++; $display("FAIL areset_out got uaddr=%0d uvalid=%0b ulast=%0b want 0/0/0", bus.uaddr, bus.uvalid, bus.ulast);
    end
    n_vec++; if (bus.ir_ready !== 1'b1 || bus.illegal_err !== 1'b0) begin
      n_bad++; $display("FAIL areset_ctl got ready=%0b err=%0b want 1/0", bus.ir_ready, bus.illegal_err);
    end
`ifdef MICRO_SEQUENCER_PERF_EN
    n_vec++; if (retired_cnt !== 16'd0) begin n_bad++; $display("FAIL areset_retired got %0d want 0", retired_cnt); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    n_vec++; if (bus.uvalid !== 1'b0 || bus.ir_ready !== 1'b1) begin n_bad++; $display("FAIL areset_post got uvalid=%0b ready=%0b want 0/1", bus.uvalid, bus.ir_ready); end
    next_cycle();
  endtask

  // Random traffic against a queue-of-addresses model: an accepted routine
  // pushes its whole address list; each unstalled cycle retires the head,
  // and an early-exit or final step drops what is left.
  task automatic test_random();
    int          exp_q[$];
    bit          trap_m;
    bit          err_m;
    logic [15:0] ret_m;
    bit          busy, e_last, e_ready, acc, legal;
    int          op;
    trap_m = 1'b0;
    err_m  = 1'b0;
    ret_m  = 16'd0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      bus.ir_valid = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) < 8) bus.ir = {4'($urandom_range(0, 15)), 4'h0};
      else bus.ir = {4'($urandom_range(0, 15)), 4'($urandom_range(1, 15))};
      bus.stall   = ($urandom_range(0, 4) == 0);
      bus.zflag   = ($urandom_range(0, 1) == 1);
      bus.err_clr = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      busy    = (exp_q.size() != 0);
      e_last  = busy && (trap_m || exp_q.size() == 1 || (exp_q[0] == 8 && bus.zflag && !bus.stall));
      e_ready = !busy || (!trap_m && e_last && !bus.stall);
      n_vec++; if (bus.uaddr !== (busy ? 5'(exp_q[0]) : 5'd0)) begin n_bad++; $display("FAIL rnd_uaddr cyc=%0d got %0d want %0d", cyc, bus.uaddr, busy ? exp_q[0] : 0); end
      n_vec++; if (bus.uvalid !== busy)     begin n_bad++; $display("FAIL rnd_uvalid cyc=%0d got %0b want %0b", cyc, bus.uvalid, busy); end
      n_vec++; if (bus.ulast !== e_last)    begin n_bad++; $display("FAIL rnd_ulast cyc=%0d got %0b want %0b", cyc, bus.ulast, e_last); end
      n_vec++; if (bus.ir_ready !== e_ready) begin n_bad++; $display("FAIL rnd_ready cyc=%0d got %0b want %0b", cyc, bus.ir_ready, e_ready); end
      n_vec++; if (bus.illegal_err !== err_m) begin n_bad++; $display("FAIL rnd_err cyc=%0d got %0b want %0b", cyc, bus.illegal_err, err_m); end
`ifdef MICRO_SEQUENCER_PERF_EN
      n_vec++; if (retired_cnt !== ret_m)   begin n_bad++; $display("FAIL rnd_retired cyc=%0d got %0d want %0d", cyc, retired_cnt, ret_m); end
`endif
      // advance the model across the coming edge
      acc   = bus.ir_valid && e_ready;
      legal = (bus.ir[3:0] == 4'h0);
      if (busy && !trap_m && e_last && !bus.stall) ret_m = ret_m + 16'd1;
      if (busy) begin
        if (trap_m) begin
          exp_q.delete();
          trap_m = 1'b0;
        end else if (!bus.stall) begin
          if (e_last) exp_q.delete();
          else void'(exp_q.pop_front());
        end
      end
      if (acc) begin
        if (legal) begin
          op = int'(bus.ir[7:4]);
          for (int i = 0; i < len_ref[op]; i++) exp_q.push_back(start_ref[op] + i);
        end else begin
          exp_q.push_back(24);
          trap_m = 1'b1;
        end
      end
      if (acc && !legal) err_m = 1'b1;
      else if (bus.err_clr) err_m = 1'b0;
      next_cycle();
    end
    // drain and clear the sticky flag before the directed tests
    idle_inputs();
    bus.err_clr = 1'b1;
    repeat (6) next_cycle();
    bus.err_clr = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
    test_random();
    test_mul();
    test_back_to_back();
    test_jmpnz();
    test_stall();
    test_illegal();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Parametrised successor to the control-unit opcode mapper.
- Accepts an instruction word through a valid/ready handshake and maps its opcode to a microroutine start address.
- Steps the micro-address through a per-opcode routine length, and supports stall, a conditional early-exit for JMPNZ, and illegal-opcode trapping.
- Sits between the instruction register and the microcode ROM of each core.

Parameters:
IR_W, 8, instruction register width; must be >= OPC_W.
OPC_W, 4, opcode width, taken from IR[IR_W-1 -: OPC_W].
UADDR_W, 5, micro-address width; must hold TRAP_ADDR.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ir  in  IR_W  instruction word
ir_valid  in  1  instruction offered
ir_ready  out  1  sequencer can accept an instruction this cycle
zflag  in  1  datapath zero flag, sampled by JMPNZ step 0
stall  in  1  hold the current micro-address (memory wait)
err_clr  in  1  clear sticky illegal_err
uaddr  out  UADDR_W  current micro-address
uvalid  out  1  uaddr is an executing micro-step
ulast  out  1  current step is the routine's final step
illegal_err  out  1  sticky illegal-instruction flag

Behaviour:
- Reset values: state IDLE; uaddr=0, uvalid=0, ulast=0, illegal_err=0, ir_ready=1. Reset mid-routine aborts immediately. The latched IR is discarded.
- States: IDLE, EXEC, TRAP.
- ir_ready = (IDLE) | (EXEC & ulast & !stall). This allows back-to-back issue with no bubble. ir_ready=0 in TRAP and on any stalled cycle.
- Accept: ir_valid & ir_ready at edge N. The opcode is latched, and in cycle N+1: uaddr=START[op], uvalid=1, step=0.
- Legality:
  - An instruction is illegal if the low IR_W-OPC_W bits are nonzero, or if op >= 16 (possible only when OPC_W>4).
  - Illegal accept -> TRAP for exactly one cycle: uaddr=TRAP_ADDR(24), uvalid=1, ulast=1, illegal_err set. Then IDLE; ir_ready=0 during TRAP.
- Start/length table (op: start,len):
  0 RSTALL 1,1; 1 CONST 2,2; 2 MOV 4,1; 3 SIZE 5,2; 4 SUB 7,1; 5 JMPNZ 8,2; 6 MOV02 10,1; 7 ADDX 11,1; 8 ADDY 12,1; 9 MUL 13,3; 10 ADD 16,1; 11 LOAD 17,2; 12 MOV13 19,1; 13 INCI 20,1; 14 STORE 21,2; 15 RSTI 23,1.
- EXEC:
  - Each non-stalled cycle: step+1, uaddr+1.
  - ulast = (step == len-1).
  - On ulast & !stall: go to IDLE, or load a new routine if a new instruction is accepted in the same cycle.
- JMPNZ: at step 0 (uaddr 8), if zflag=1 then ulast is forced to 1 and the routine ends. If zflag=0, the routine proceeds to uaddr 9. zflag is sampled only on non-stalled cycles.
- Stall: uaddr, ulast and step are frozen. uvalid stays 1. Stall in IDLE has no effect on acceptance.
- illegal_err: set has priority over err_clr in the same cycle. Otherwise err_clr clears it the next edge.
- In IDLE: uaddr=0, uvalid=0, ulast=0.
- Widths: step counter is 2 bits (max len 3). uaddr never wraps within a routine by table construction.

Optional Feature:
- Macro: MICRO_SEQUENCER_PERF_EN.
- Defined: adds output retired_cnt[15:0]. It increments on every completed legal routine (ulast & uvalid & !stall, excluding TRAP) and wraps 0xFFFF -> 0. It resets to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package mseq_pkg holds:
  - opcode enum (RSTALL..RSTI)
  - START and LEN constant arrays
  - TRAP_ADDR = 24
  - state enum
- One sub-module, mseq_map: a combinational opcode -> {start, len, legal} ROM (the generalised mapper). Instantiated once.

Test Plan:
- Reset, then ir=0x90 (MUL) with ir_valid: uaddr sequence 13,14,15 in consecutive cycles; ulast on 15; ir_ready high in the 15 cycle.
- ADD (0xA0) offered during the final MUL cycle: uaddr 15 then 16 with no bubble; uvalid stays 1.
- JMPNZ (0x50) with zflag=1: single step uaddr=8, ulast=1. Repeat with zflag=0: uaddr 8,9.
- LOAD (0xB0) with stall high for 3 cycles at step 0: uaddr held at 17 for 4 cycles total, ir_ready=0, then 18.
- ir=0x02 then ir=0xF1: each gives one TRAP cycle with uaddr=24 and illegal_err=1. err_clr pulse clears it; err_clr coincident with a new illegal instruction leaves it 1.
- rst_n low mid-MUL at uaddr 14: outputs return to reset values immediately (async); retired_cnt=0 when MICRO_SEQUENCER_PERF_EN is defined.
